// File: rtl/multi_port_grf.sv
// Multi-read, dual-write register file with per-register 2-bit pending-writer counters.
// Optional macro GRF_BYPASS_EN forwards same-cycle write data onto the read ports.
module multi_port_grf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_ready
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r    [DEPTH];
  logic [1:0]        cnt_r     [DEPTH];
  logic [1:0]        cnt_nxt_s [DEPTH];
  logic [2:0]        tot_s     [DEPTH];
  logic [2:0]        dn_s      [DEPTH];
  logic [ADDR_W-1:0] ra_s      [NUM_RD];
  logic              wv0_s;
  logic              wv1_s;
  logic              iss_acc_s;

  // Write qualification and issue acceptance; index 0 never participates
  always_comb begin
    wv0_s     = we0 & (|wa0);
    wv1_s     = we1 & (|wa1);
    iss_ready = reset | (cnt_r[iss_addr] != 2'd3);
    iss_acc_s = ~reset & iss_en & iss_ready & (|iss_addr);
  end

  // Net counter change per register: +issue -writes, clamped to 0..3
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      dn_s[i]  = {2'b00, wv0_s && (wa0 == ADDR_W'(i))}
               + {2'b00, wv1_s && (wa1 == ADDR_W'(i))};
      tot_s[i] = {1'b0, cnt_r[i]} + {2'b00, iss_acc_s && (iss_addr == ADDR_W'(i))};
      if (tot_s[i] <= dn_s[i]) begin
        cnt_nxt_s[i] = 2'd0;
      end else if ((tot_s[i] - dn_s[i]) > 3'd3) begin
        cnt_nxt_s[i] = 2'd3;
      end else begin
        cnt_nxt_s[i] = 2'(tot_s[i] - dn_s[i]);
      end
    end
  end

  // Storage and counter state; port 1 is written last so it wins on a collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
        cnt_r[i]  <= 2'd0;
      end
    end else begin
      if (wv0_s) begin
        regs_r[wa0] <= wd0;
      end
      if (wv1_s) begin
        regs_r[wa1] <= wd1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Combinational read ports and busy flags, forced quiet while reset is high
  always_comb begin
    rd    = {NUM_RD*DATA_W{1'b0}};
    rbusy = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      ra_s[k] = ra[k*ADDR_W +: ADDR_W];
      if (reset || (ra_s[k] == {ADDR_W{1'b0}})) begin
        rd[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rbusy[k]               = 1'b0;
      end else begin
`ifdef GRF_BYPASS_EN
        if (wv1_s && (wa1 == ra_s[k])) begin
          rd[k*DATA_W +: DATA_W] = wd1;
        end else if (wv0_s && (wa0 == ra_s[k])) begin
          rd[k*DATA_W +: DATA_W] = wd0;
        end else begin
          rd[k*DATA_W +: DATA_W] = regs_r[ra_s[k]];
        end
`else
        rd[k*DATA_W +: DATA_W] = regs_r[ra_s[k]];
`endif
        rbusy[k] = (cnt_r[ra_s[k]] != 2'd0);
      end
    end
  end

endmodule

// File: tb/tb_multi_port_grf.sv
// Scoreboard bench for multi_port_grf: directed scenarios then random traffic,
// checked against an array-based model (honours GRF_BYPASS_EN like the design).
module tb_multi_port_grf;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 3;
  localparam int DEPTH  = 2 ** ADDR_W;
`ifdef GRF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rbusy;
  logic                     we0, we1, iss_en, iss_ready;
  logic [ADDR_W-1:0]        wa0, wa1, iss_addr;
  logic [DATA_W-1:0]        wd0, wd1;

  multi_port_grf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rbusy;
    logic                     rdy;
    int                       id;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_cnt [DEPTH];

  function automatic logic [NUM_RD*ADDR_W-1:0] pk(input int a0, input int a1, input int a2);
    logic [NUM_RD*ADDR_W-1:0] v;
    v = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    return v;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.id    = step_id;
    e.rd    = '0;
    e.rbusy = '0;
    e.rdy   = reset ? 1'b1 : (m_cnt[iss_addr] != 3);
    for (int k = 0; k < NUM_RD; k++) begin
      int a;
      logic [DATA_W-1:0] d;
      a = int'(ra[k*ADDR_W +: ADDR_W]);
      d = '0;
      if (!reset && a != 0) begin
        d = m_mem[a];
        if (BYPASS && we1 && int'(wa1) == a) d = wd1;
        else if (BYPASS && we0 && int'(wa0) == a) d = wd0;
        e.rbusy[k] = (m_cnt[a] != 0);
      end
      e.rd[k*DATA_W +: DATA_W] = d;
    end
    return e;
  endfunction

  task automatic commit();
    int delta [DEPTH];
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) delta[i] = 0;
      if (iss_en && iss_addr != 0 && m_cnt[iss_addr] < 3) delta[iss_addr] += 1;
      if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; delta[wa0] -= 1; end
      if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; delta[wa1] -= 1; end
      for (int i = 0; i < DEPTH; i++) begin
        int n;
        n = m_cnt[i] + delta[i];
        m_cnt[i] = (n < 0) ? 0 : ((n > 3) ? 3 : n);
      end
    end
  endtask

  // Drive one cycle of inputs, push the expectation, then advance the model past the edge
  task automatic step(input logic r, input logic e0, input int a0, input logic [DATA_W-1:0] d0,
                      input logic e1, input int a1, input logic [DATA_W-1:0] d1,
                      input logic ie, input int ia, input logic [NUM_RD*ADDR_W-1:0] rav);
    reset = r; we0 = e0; wa0 = ADDR_W'(a0); wd0 = d0;
    we1 = e1; wa1 = ADDR_W'(a1); wd1 = d1;
    iss_en = ie; iss_addr = ADDR_W'(ia); ra = rav;
    step_id++;
    sb_q.push_back(predict());
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic idle_read(input logic [NUM_RD*ADDR_W-1:0] rav);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 0, rav);
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
  endfunction

  // Monitor: compare the oldest expectation with what the DUT shows mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks += 3;
        if (rd !== e.rd) begin
          n_errors++;
          $display("FAIL rd step=%0d got=%h exp=%h", e.id, rd, e.rd);
        end
        if (rbusy !== e.rbusy) begin
          n_errors++;
          $display("FAIL rbusy step=%0d got=%b exp=%b", e.id, rbusy, e.rbusy);
        end
        if (iss_ready !== e.rdy) begin
          n_errors++;
          $display("FAIL iss_ready step=%0d got=%b exp=%b", e.id, iss_ready, e.rdy);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_cnt[i] = 0; end
    reset = 1'b1; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    iss_en = 1'b0; iss_addr = '0; ra = '0;
    @(posedge clk);
    #1;
    // Reset with a write and an issue in flight: both must be dropped
    step(1'b1, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, '0, 1'b1, 5, pk(5, 5, 5));
    idle_read(pk(5, 5, 5));
    // Same-cycle write/read, then the registered value
    step(1'b0, 1'b1, 3, 32'h0000_1234, 1'b0, 0, '0, 1'b0, 0, pk(3, 0, 5));
    idle_read(pk(3, 3, 0));
    // Two writes to one index: port 1 wins
    step(1'b0, 1'b1, 7, 32'h0000_AAAA, 1'b1, 7, 32'h0000_5555, 1'b0, 0, pk(7, 3, 7));
    idle_read(pk(7, 0, 3));
    // Fill index 9 to saturation, fourth issue refused, then drain with three writes
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 9, pk(9, 9, 0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9, 32'(i + 16'h900), 1'b0, 0, '0, 1'b0, 9, pk(9, 0, 9));
    idle_read(pk(9, 9, 9));
    // Issue to 4, then issue+write to 4 leaves one reservation
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 4, pk(4, 0, 0));
    step(1'b0, 1'b1, 4, 32'h0000_4444, 1'b0, 0, '0, 1'b1, 4, pk(4, 4, 0));
    idle_read(pk(4, 0, 4));
    // Register 0 ignores writes and issues
    step(1'b0, 1'b1, 0, 32'h0000_FFFF, 1'b1, 0, 32'h0000_FFFF, 1'b1, 0, pk(0, 0, 0));
    idle_read(pk(0, 4, 0));
    // Load index 2, reserve twice, then reset mid-operation
    step(1'b0, 1'b1, 2, 32'h2222_2222, 1'b0, 0, '0, 1'b1, 2, pk(2, 0, 0));
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 2, pk(2, 2, 0));
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 2, pk(2, 2, 2));
    step(1'b1, 1'b1, 2, 32'h1, 1'b1, 3, 32'h2, 1'b1, 2, pk(2, 3, 7));
    idle_read(pk(2, 3, 7));
    // Random traffic over a narrow address range to force collisions
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0),
           $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
           $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
           $urandom_range(0, 1) == 1, rnd_addr(),
           pk(rnd_addr(), rnd_addr(), rnd_addr()));
    end
    idle_read(pk(1, 2, 3));
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_port_grf.md
MULTI_PORT_GRF -- requirements
Module: multi_port_grf

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports (legal range 1..4).
REQ-004 The block SHALL use reset reset, synchronous, active-high, and clock clk.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ra  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  port k register has outstanding writers.
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write port 0.
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1 (younger instruction).
- iss_en  in  1  issue request: reserve one pending write to iss_addr.
- iss_addr  in  ADDR_W  destination of issuing instruction.
- iss_ready  out  1  issue may be accepted this cycle.

Function
REQ-006 Register 0 SHALL always read 0; writes and issues to index 0 are ignored and never counted.
REQ-007 Writes SHALL take effect at posedge clk when weN=1 and waN!=0.
REQ-008 If we0 and we1 target the same index in one cycle, wd1 SHALL be stored.
REQ-009 Reads SHALL be combinational: rd[k] = current content of ra[k], subject to REQ-010.
REQ-010 Bypass (when GRF_BYPASS_EN is defined): if a same-cycle write hits ra[k]!=0, rd[k] SHALL return the write data, with port 1 taking priority over port 0.
REQ-011 Each register SHALL have a 2-bit pending counter, cnt, reset to 0.
REQ-012 iss_ready SHALL be 0 when cnt[iss_addr]==3; otherwise 1. This is combinational from iss_addr and cnt.
REQ-013 An issue is accepted when iss_en && iss_ready && iss_addr!=0; an accepted issue SHALL increment cnt[iss_addr] at posedge.
REQ-014 Each valid write (weN && waN!=0) SHALL decrement cnt[waN] by 1 at posedge. Two writes to the same index SHALL decrement it by 2.
REQ-015 Decrements SHALL saturate at 0; a write to a register with cnt==0 performs the data write only.
REQ-016 A same-cycle accepted issue and write(s) to one index SHALL apply the net change (+1 -w), with results clamped to 0..3.
REQ-017 rbusy[k] SHALL be (cnt[ra[k]]!=0), taken from the pre-edge counter value; rbusy for index 0 is always 0.
REQ-018 No read latency; write-to-read latency is 0 cycles with bypass and 1 cycle without.

Reset
REQ-019 On reset at posedge: all registers SHALL be 0 and all cnt SHALL be 0. Writes and issues in the same cycle SHALL be discarded.
REQ-020 During reset: iss_ready=1, rbusy=0, and rd returns 0 for every port. Bypass SHALL be suppressed while reset=1.
REQ-021 Reset mid-operation SHALL drop all outstanding reservations; no recovery state is retained.

Configuration
REQ-022 Macro GRF_BYPASS_EN. When defined, REQ-010 forwarding is present. When undefined, rd reflects stored content only and the write muxes in the read path are absent. All other behaviour is identical.

Verification
REQ-023 Reset, then read all ports at index 5 -> rd=0, rbusy=0, iss_ready=1.
REQ-024 we0=1, wa0=3, wd0=0x1234 with ra[0]=3 in the same cycle -> rd[0]=0x1234 with bypass; rd[0]=0 without bypass, then 0x1234 on the next cycle.
REQ-025 we0/wa0=7/wd0=0xAAAA and we1/wa1=7/wd1=0x5555 in one cycle -> reg7=0x5555; a bypassed read of 7 in that cycle returns 0x5555.
REQ-026 Issue to index 9 four times in consecutive cycles -> cnt=3 after three; the 4th cycle has iss_ready=0 and is not counted. Then three writes to 9 -> rbusy returns to 0 after the third.
REQ-027 Issue and write to index 4 in the same cycle with cnt=1 -> cnt remains 1. Write to 0 with 0xFFFF -> reads of 0 return 0, and rbusy for index 0 stays 0.
REQ-028 cnt[2]=2 with data loaded, then assert reset -> next cycle all rd=0, rbusy=0, iss_ready=1.
